// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and frame layout, also used by the downstream keyboard decoder.
package ps2_pkg;

    localparam int PS2_FRAME_BITS  = 11;
    localparam int PS2_DEPTH       = 8;
    localparam int PS2_TIMEOUT_CYC = 50000;

    // Wire order on the bus: start first, stop last (bit0 = start).
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
        logic       start;
    } ps2_frame_t;

    function automatic logic frame_ok(input ps2_frame_t f);
        return !f.start && f.stop && (^{f.data, f.parity});
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO with extra-MSB pointers; storage is deliberately not reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr, do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign drop  = wr_en && !do_wr;

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise, deserialise 11-bit frames, queue good scan codes.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH       = PS2_DEPTH,
    parameter int TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]    LAST_BIT = 4'(PS2_FRAME_BITS - 1);
    localparam logic [TW-1:0] TMO      = TW'(TIMEOUT_CYC);

    logic [2:0]                kclk_s;
    logic [1:0]                kdat_s;
    logic [PS2_FRAME_BITS-1:0] shreg;
    logic [3:0]                bitcnt;
    logic [TW-1:0]             tcnt;
    logic                      nd_q;
    logic                      fall, last, timeout, good;
    ps2_frame_t                frame;
    logic                      wr_en, rd_en, empty, full, drop;

    // Two flops to synchronise, the third holds the previous sample for edge detect.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            kclk_s <= 3'b111;
            kdat_s <= 2'b11;
        end else begin
            kclk_s <= {kclk_s[1:0], ps2_clk};
            kdat_s <= {kdat_s[0], ps2_data};
        end
    end

    assign fall    = kclk_s[2] && !kclk_s[1];
    assign last    = fall && (bitcnt == LAST_BIT);
    assign timeout = (bitcnt != 4'd0) && (tcnt == TMO);
    assign frame   = ps2_frame_t'({kdat_s[1], shreg[PS2_FRAME_BITS-1:1]});
    assign good    = frame_ok(frame);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            shreg  <= '0;
            bitcnt <= 4'd0;
        end else if (fall) begin
            shreg  <= frame;
            bitcnt <= last ? 4'd0 : bitcnt + 4'd1;
        end else if (timeout) begin
            bitcnt <= 4'd0;
        end
    end

    // Idle while no frame is in progress; a stalled frame is silently abandoned.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                               tcnt <= '0;
        else if (fall || bitcnt == 4'd0 || timeout) tcnt <= '0;
        else                                     tcnt <= tcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            nd_q      <= 1'b1;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            nd_q      <= nextdata_n;
            frame_err <= last && !good;
            overflow  <= overflow || drop;
        end
    end

    assign wr_en = last && good;
    assign rd_en = nd_q && !nextdata_n;
    assign ready = !empty;

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .wr_en   (wr_en),
        .wr_data (frame.data),
        .rd_en   (rd_en),
        .rd_data (data),
        .empty   (empty),
        .full    (full),
        .drop    (drop)
    );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: table of single frames plus multi-frame corner sequences.
module tb_ps2_rx_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 2000;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready, overflow, frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int err_seen = 0;
    logic r2, r3;

    ps2_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Number of clk cycles frame_err was high.
    always @(negedge clk) if (frame_err === 1'b1) err_seen++;

    typedef struct {
        logic [7:0] b;
        bit         flip_par;
        bit         stop_b;
        bit         start_b;
        bit         exp_ok;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives nedges bits of a frame. After the last falling edge, r2/r3 capture ready
    // two and three clk edges later (sync + edge flop = write on the third edge).
    // pop_end lines a pop up with that same write edge.
    task automatic send(input logic [7:0] b, input bit flip_par, input bit stop_b,
                        input bit start_b, input int nedges, input int period, input bit pop_end);
        logic [10:0] f;
        int half;
        half = period / 2;
        f = {stop_b, (~^b) ^ flip_par, b, start_b};
        for (int i = 0; i < nedges; i++) begin
            @(negedge clk) ps2_data = f[i];
            repeat (half - 1) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == nedges - 1) begin
                @(negedge clk);
                @(negedge clk);
                r2 = ready;
                if (pop_end) nextdata_n = 1'b0;
                @(negedge clk);
                r3 = ready;
                nextdata_n = 1'b1;
                repeat (half - 3) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk) nextdata_n = 1'b0;
        @(negedge clk) nextdata_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) clrn = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    vec_t vt[6];

    initial begin
        int e0;
        vt[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[4] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[5] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_ready", ready, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_frame_err", frame_err, 0);
        clrn = 1'b1;
        @(negedge clk);

        // Single frames: first at 100-clk PS/2 period, rest faster.
        for (int i = 0; i < 6; i++) begin
            e0 = err_seen;
            send(vt[i].b, vt[i].flip_par, vt[i].stop_b, vt[i].start_b, 11, (i == 0) ? 100 : 40, 1'b0);
            chk($sformatf("v%0d_ready_at2", i), r2, 0);
            chk($sformatf("v%0d_ready_at3", i), r3, vt[i].exp_ok);
            chk($sformatf("v%0d_ready", i), ready, vt[i].exp_ok);
            chk($sformatf("v%0d_err_cycles", i), err_seen - e0, vt[i].exp_ok ? 0 : 1);
            if (vt[i].exp_ok) begin
                chk($sformatf("v%0d_data", i), data, vt[i].b);
                pop();
                chk($sformatf("v%0d_drained", i), ready, 0);
            end
        end

        // Long low nextdata_n pops exactly once.
        send(8'hF0, 0, 1, 0, 11, 40, 0);
        send(8'h1C, 0, 1, 0, 11, 40, 0);
        chk("two_head", data, 8'hF0);
        @(negedge clk) nextdata_n = 1'b0;
        repeat (300) @(negedge clk);
        chk("hold_ready", ready, 1);
        chk("hold_data", data, 8'h1C);
        nextdata_n = 1'b1;
        @(negedge clk);
        pop();
        chk("hold_drained", ready, 0);
        pop();
        chk("pop_empty_ignored", ready, 0);

        // Overflow: 9 frames into 8 slots.
        for (int i = 1; i <= 9; i++) begin
            send(8'(i), 0, 1, 0, 11, 40, 0);
            if (i == 8) chk("ovf_before", overflow, 0);
        end
        chk("ovf_after", overflow, 1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ovf_pop%0d", i), data, i);
            pop();
        end
        chk("ovf_drained", ready, 0);
        chk("ovf_sticky", overflow, 1);

        // Reset mid-frame with 3 queued entries.
        for (int i = 0; i < 3; i++) send(8'h60 + 8'(i), 0, 1, 0, 11, 40, 0);
        chk("q3_ready", ready, 1);
        send(8'h77, 0, 1, 0, 4, 40, 0);
        @(negedge clk) clrn = 1'b0;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_overflow", overflow, 0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        send(8'h15, 0, 1, 0, 11, 40, 0);
        chk("rst_next_data", data, 8'h15);
        chk("rst_next_ready", ready, 1);

        // Pop coinciding with write at count 1.
        send(8'h33, 0, 1, 0, 11, 40, 1);
        chk("one_pw_ready", ready, 1);
        chk("one_pw_data", data, 8'h33);
        pop();
        chk("one_pw_drained", ready, 0);

        // Pop coinciding with write when full.
        do_reset();
        for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), 0, 1, 0, 11, 40, 0);
        send(8'h48, 0, 1, 0, 11, 40, 1);
        chk("full_pw_overflow", overflow, 0);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("full_pw_pop%0d", i), data, 8'h40 + 8'(i));
            pop();
        end
        chk("full_pw_drained", ready, 0);

        // Partial frame abandoned by timeout.
        do_reset();
        e0 = err_seen;
        send(8'h55, 0, 1, 0, 5, 40, 0);
        repeat (TMO + 10) @(negedge clk);
        send(8'h2A, 0, 1, 0, 11, 40, 0);
        chk("tmo_ready", ready, 1);
        chk("tmo_data", data, 8'h2A);
        chk("tmo_no_err", err_seen - e0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
